dram_responder: RTL and testbench

- Memory-side endpoint of the backend DRAM interface: accepts command, address and write-data streams, and returns read data in order.
- Backs a synthesizable word-addressed store with a fixed read latency, an init-complete delay and bounded buffering.
- Used as the DRAM stand-in for backend bring-up and regression, and on FPGA builds without a memory controller.

---
 rtl/dram_responder_if.sv | 33 +++
 rtl/dram_responder.sv | 172 +++++++++++++++++
 tb/tb_dram_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_responder_if.sv
// Backend DRAM command/write/read streams plus status, as seen between a backend and its memory.
interface dram_responder_if #(
    parameter int DDRAWidth = 28,
    parameter int DDRCWidth = 3,
    parameter int DDRDWidth = 512
);
    logic [DDRAWidth-1:0] DRAMCommandAddress;
    logic [DDRCWidth-1:0] DRAMCommand;
    logic                 DRAMCommandValid;
    logic                 DRAMCommandReady;
    logic [DDRDWidth-1:0] DRAMWriteData;
    logic                 DRAMWriteDataValid;
    logic                 DRAMWriteDataReady;
    logic [DDRDWidth-1:0] DRAMReadData;
    logic                 DRAMReadDataValid;
    logic                 DRAMReadDataReady;
    logic                 DRAMInitComplete;
    logic                 IllegalCommand;

    modport master (
        output DRAMCommandAddress, DRAMCommand, DRAMCommandValid,
        output DRAMWriteData, DRAMWriteDataValid, DRAMReadDataReady,
        input  DRAMCommandReady, DRAMWriteDataReady, DRAMReadData, DRAMReadDataValid,
        input  DRAMInitComplete, IllegalCommand
    );

    modport slave (
        input  DRAMCommandAddress, DRAMCommand, DRAMCommandValid,
        input  DRAMWriteData, DRAMWriteDataValid, DRAMReadDataReady,
        output DRAMCommandReady, DRAMWriteDataReady, DRAMReadData, DRAMReadDataValid,
        output DRAMInitComplete, IllegalCommand
    );
endinterface

// File: rtl/dram_responder.sv
// DRAM stand-in: word store with in-order read returns, ReadLatency+1 cycles accept-to-valid.
// Reads are credit-limited by read FIFO space, writes wait for a buffered beat; nothing stalls downstream.
module dram_responder_fifo #(
    parameter  int Width = 8,
    parameter  int Depth = 4,
    localparam int PtrW  = $clog2(Depth),
    localparam int CntW  = $clog2(Depth + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic [Width-1:0] pushDat,
    input  logic             pop,
    output logic [Width-1:0] headDat,
    output logic [CntW-1:0]  count
);
    logic [Width-1:0] store [Depth];
    logic [PtrW-1:0]  wrPtr;
    logic [PtrW-1:0]  rdPtr;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PtrW'(1);
            if (pop)  rdPtr <= rdPtr + PtrW'(1);
            count <= count + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge Clock) begin
        if (push) store[wrPtr] <= pushDat;
    end

    assign headDat = store[rdPtr];
endmodule

module dram_responder #(
    parameter int DDRAWidth   = 28,
    parameter int DDRCWidth   = 3,
    parameter int DDRDWidth   = 512,
    parameter int MemAWidth   = 10,
    parameter int AddrShift   = 3,
    parameter int ReadLatency = 4,
    parameter int WrFIFODepth = 4,
    parameter int RdFIFODepth = 4,
    parameter int InitDelay   = 16
) (
    input  logic           Clock,
    input  logic           Reset,
    dram_responder_if.slave dram
);
    localparam int WrCntW = $clog2(WrFIFODepth + 1);
    localparam int OutW   = $clog2(RdFIFODepth + 1);
    localparam int InitW  = $clog2(InitDelay + 1);
    localparam logic [DDRCWidth-1:0] CmdWrite = DDRCWidth'(0);
    localparam logic [DDRCWidth-1:0] CmdRead  = DDRCWidth'(1);

    typedef enum logic {INIT, RUN} initState_t;
    initState_t state, stateNext;

    logic [InitW-1:0]     initCnt;
    logic                 initComplete;
    logic                 cmdReady;
    logic                 isWrite, isRead;
    logic                 accept, wrAccept, rdAccept, illAccept;
    logic [MemAWidth-1:0] memIndex;
    logic                 unusedAddr;
    logic [WrCntW-1:0]    wrCount;
    logic [DDRDWidth-1:0] wrHead;
    logic                 wrPush;
    logic [OutW-1:0]      rdCount;
    logic [DDRDWidth-1:0] rdHead;
    logic                 rdValid, rdPop;
    logic [OutW-1:0]      outstanding;
    logic                 illegalSticky;
    logic [DDRDWidth-1:0] mem [2**MemAWidth];
    logic [ReadLatency-1:0] pipeVld;
    logic [DDRDWidth-1:0]   pipeDat [ReadLatency];

    assign isWrite   = (dram.DRAMCommand == CmdWrite);
    assign isRead    = (dram.DRAMCommand == CmdRead);
    assign accept    = dram.DRAMCommandValid & cmdReady;
    assign wrAccept  = accept & isWrite;
    assign rdAccept  = accept & isRead;
    assign illAccept = accept & !isWrite & !isRead;

    // Bits outside the beat-index field are don't-care, so the address space aliases.
    assign memIndex   = dram.DRAMCommandAddress[AddrShift +: MemAWidth];
    assign unusedAddr = ^dram.DRAMCommandAddress;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= INIT;
        else        state <= stateNext;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)              initCnt <= '0;
        else if (state == INIT)  initCnt <= initCnt + InitW'(1);
    end

    always_comb begin
        stateNext    = state;
        initComplete = 1'b0;
        cmdReady     = 1'b0;
        case (state)
            INIT: if (initCnt == InitW'(InitDelay - 1)) stateNext = RUN;
            RUN: begin
                initComplete = 1'b1;
                if (isWrite)     cmdReady = (wrCount != '0);
                else if (isRead) cmdReady = (outstanding < OutW'(RdFIFODepth));
                else             cmdReady = 1'b1;
            end
            default: stateNext = INIT;
        endcase
    end

    assign dram.DRAMWriteDataReady = Reset & (wrCount != WrCntW'(WrFIFODepth));
    assign wrPush = dram.DRAMWriteDataValid & dram.DRAMWriteDataReady;

    dram_responder_fifo #(.Width(DDRDWidth), .Depth(WrFIFODepth)) wrFifo (
        .Clock(Clock), .Reset(Reset),
        .push(wrPush), .pushDat(dram.DRAMWriteData),
        .pop(wrAccept), .headDat(wrHead), .count(wrCount)
    );

    always_ff @(posedge Clock) begin
        if (wrAccept) mem[memIndex] <= wrHead;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pipeVld <= '0;
        end else begin
            pipeVld[0] <= rdAccept;
            for (int i = 1; i < ReadLatency; i++) pipeVld[i] <= pipeVld[i-1];
        end
    end

    always_ff @(posedge Clock) begin
        if (rdAccept) pipeDat[0] <= mem[memIndex];
        for (int i = 1; i < ReadLatency; i++) pipeDat[i] <= pipeDat[i-1];
    end

    // Credits cover pipeline plus FIFO, so a push here always finds room.
    dram_responder_fifo #(.Width(DDRDWidth), .Depth(RdFIFODepth)) rdFifo (
        .Clock(Clock), .Reset(Reset),
        .push(pipeVld[ReadLatency-1]), .pushDat(pipeDat[ReadLatency-1]),
        .pop(rdPop), .headDat(rdHead), .count(rdCount)
    );

    assign rdValid = (rdCount != '0);
    assign rdPop   = rdValid & dram.DRAMReadDataReady;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            outstanding   <= '0;
            illegalSticky <= 1'b0;
        end else begin
            outstanding <= outstanding + OutW'(rdAccept) - OutW'(rdPop);
            if (illAccept) illegalSticky <= 1'b1;
        end
    end

    assign dram.DRAMCommandReady  = cmdReady;
    assign dram.DRAMReadDataValid = rdValid;
    assign dram.DRAMReadData      = rdValid ? rdHead : '0;
    assign dram.DRAMInitComplete  = initComplete;
    assign dram.IllegalCommand    = illegalSticky;
endmodule

// File: tb/tb_dram_responder.sv
// Scoreboarded bench for dram_responder: init gate, RAW, missing write data, read credits, wrap, illegal, reset.
module tb_dram_responder;
    localparam int AW = 28;
    localparam int CW = 3;
    localparam int DW = 512;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    dram_responder_if #(.DDRAWidth(AW), .DDRCWidth(CW), .DDRDWidth(DW)) dram ();
    dram_responder dut (.Clock(Clock), .Reset(Reset), .dram(dram));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int returned = 0;

    logic [DW-1:0] mdl [int];
    logic [DW-1:0] wq [$];
    logic [DW-1:0] sbDat [$];
    bit            sbCare [$];

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(i);
        return {16{w}};
    endfunction

    // Reference model, sampled mid-cycle while inputs are stable.
    always @(negedge Clock) begin
        int idx;
        logic [DW-1:0] d;
        bit c;
        if (Reset) begin
            if (dram.DRAMCommandValid && dram.DRAMCommandReady) begin
                idx = int'((dram.DRAMCommandAddress >> 3) & 28'h3FF);
                if (dram.DRAMCommand == 3'd0) begin
                    chk("wr_beat_avail", 512'(wq.size() != 0), 512'd1);
                    if (wq.size() != 0) mdl[idx] = wq.pop_front();
                end else if (dram.DRAMCommand == 3'd1) begin
                    sbCare.push_back(mdl.exists(idx));
                    sbDat.push_back(mdl.exists(idx) ? mdl[idx] : '0);
                end
            end
            if (dram.DRAMWriteDataValid && dram.DRAMWriteDataReady) wq.push_back(dram.DRAMWriteData);
            if (dram.DRAMReadDataValid && dram.DRAMReadDataReady) begin
                chk("sb_nonempty", 512'(sbDat.size() != 0), 512'd1);
                if (sbDat.size() != 0) begin
                    d = sbDat.pop_front();
                    c = sbCare.pop_front();
                    if (c) chk("sb_rd_data", dram.DRAMReadData, d);
                    returned++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic pushBeat(input logic [DW-1:0] d);
        dram.DRAMWriteData = d;
        dram.DRAMWriteDataValid = 1'b1;
        tick();
        dram.DRAMWriteDataValid = 1'b0;
    endtask

    task automatic issueCmd(input logic [CW-1:0] c, input logic [AW-1:0] a, output int acc);
        acc = -1;
        dram.DRAMCommand = c;
        dram.DRAMCommandAddress = a;
        dram.DRAMCommandValid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge Clock);
            if (dram.DRAMCommandReady) begin
                acc = cyc;
                tick();
                break;
            end
            tick();
        end
        dram.DRAMCommandValid = 1'b0;
        chk("cmd_accepted", 512'(acc >= 0), 512'd1);
    endtask

    task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int acc;
        pushBeat(d);
        issueCmd(3'd0, a, acc);
    endtask

    task automatic readExpect(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        int acc;
        int lat;
        lat = 0;
        issueCmd(3'd1, a, acc);
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clock);
            if (dram.DRAMReadDataValid) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_lat"}, 512'(lat), 512'd5);
        chk({tag, "_data"}, dram.DRAMReadData, exp);
        tick();
    endtask

    task automatic settle();
        repeat (10) tick();
    endtask

    initial begin
        int acc;
        int lat;
        int lowCnt;
        int rdyCnt;
        int nxt;
        int base;
        int vldCnt;
        logic [DW-1:0] a5;
        a5 = {64{8'hA5}};

        dram.DRAMCommandAddress = '0;
        dram.DRAMCommand = 3'd1;
        dram.DRAMCommandValid = 1'b1;
        dram.DRAMWriteData = '0;
        dram.DRAMWriteDataValid = 1'b0;
        dram.DRAMReadDataReady = 1'b1;

        repeat (3) @(negedge Clock);
        chk("rst_flags", 512'({dram.DRAMInitComplete, dram.DRAMCommandReady, dram.DRAMWriteDataReady,
                               dram.DRAMReadDataValid, dram.IllegalCommand}), 512'd0);
        chk("rst_rdata", dram.DRAMReadData, '0);

        // Init gate with a read held pending from reset release.
        @(posedge Clock); #1;
        Reset = 1'b1;
        lat = 0;
        lowCnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clock);
            if (dram.DRAMCommandReady) begin
                lat = n;
                break;
            end
            if (!dram.DRAMInitComplete) lowCnt++;
        end
        chk("init_ready_cycle", 512'(lat), 512'd17);
        chk("init_low_cycles", 512'(lowCnt), 512'd16);
        chk("init_complete", 512'(dram.DRAMInitComplete), 512'd1);
        tick();
        dram.DRAMCommandValid = 1'b0;
        settle();

        // Write then read back-to-back at the same index.
        writeWord(28'h40, a5);
        readExpect(28'h40, a5, "raw");
        settle();

        // Write command with no buffered beat; a same-cycle push must not bypass.
        dram.DRAMCommand = 3'd0;
        dram.DRAMCommandAddress = 28'h80;
        dram.DRAMCommandValid = 1'b1;
        rdyCnt = 0;
        repeat (3) begin
            @(negedge Clock);
            rdyCnt += int'(dram.DRAMCommandReady);
            tick();
        end
        chk("nodata_ready", 512'(rdyCnt), 512'd0);
        dram.DRAMWriteData = pat(99);
        dram.DRAMWriteDataValid = 1'b1;
        @(negedge Clock);
        chk("nodata_no_bypass", 512'(dram.DRAMCommandReady), 512'd0);
        tick();
        dram.DRAMWriteDataValid = 1'b0;
        @(negedge Clock);
        chk("nodata_accept", 512'(dram.DRAMCommandReady), 512'd1);
        tick();
        dram.DRAMCommandValid = 1'b0;
        readExpect(28'h80, pat(99), "nodata_rb");
        settle();

        // Read credit back-pressure.
        for (int i = 0; i < 6; i++) writeWord(28'((i + 1) << 3), pat(i));
        settle();
        base = returned;
        dram.DRAMReadDataReady = 1'b0;
        nxt = 0;
        for (int k = 0; k < 10; k++) begin
            dram.DRAMCommand = 3'd1;
            dram.DRAMCommandAddress = 28'((nxt + 1) << 3);
            dram.DRAMCommandValid = 1'b1;
            @(negedge Clock);
            if (dram.DRAMCommandReady) nxt++;
            tick();
        end
        chk("bp_accepted", 512'(nxt), 512'd4);
        dram.DRAMCommandAddress = 28'((nxt + 1) << 3);
        @(negedge Clock);
        chk("bp_blocked", 512'(dram.DRAMCommandReady), 512'd0);
        chk("bp_head_a", dram.DRAMReadData, pat(0));
        tick();
        @(negedge Clock);
        chk("bp_head_b", dram.DRAMReadData, pat(0));
        tick();
        dram.DRAMReadDataReady = 1'b1;
        tick();
        dram.DRAMReadDataReady = 1'b0;
        @(negedge Clock);
        chk("bp_after_pop", 512'(dram.DRAMCommandReady), 512'd1);
        tick();
        dram.DRAMCommandAddress = 28'(6 << 3);
        @(negedge Clock);
        chk("bp_full_again", 512'(dram.DRAMCommandReady), 512'd0);
        tick();
        dram.DRAMReadDataReady = 1'b1;
        issueCmd(3'd1, 28'(6 << 3), acc);
        settle();
        chk("bp_returned", 512'(returned - base), 512'd6);

        // Address wrap onto index 0.
        writeWord(28'h0, 512'h11);
        readExpect(28'(1 << 13), 512'h11, "wrap");
        settle();

        // Illegal code: sticky flag, no memory effect.
        issueCmd(3'd7, 28'h40, acc);
        @(negedge Clock);
        chk("illegal_set", 512'(dram.IllegalCommand), 512'd1);
        tick();
        readExpect(28'h40, a5, "illegal_mem");
        settle();
        chk("sb_drained", 512'(sbDat.size()), 512'd0);

        // Reset with reads in flight.
        issueCmd(3'd1, 28'h40, acc);
        issueCmd(3'd1, 28'h80, acc);
        Reset = 1'b0;
        sbDat.delete();
        sbCare.delete();
        wq.delete();
        @(negedge Clock);
        chk("rst2_rvalid", 512'(dram.DRAMReadDataValid), 512'd0);
        chk("rst2_illegal", 512'(dram.IllegalCommand), 512'd0);
        tick();
        tick();
        Reset = 1'b1;
        vldCnt = 0;
        repeat (12) begin
            @(negedge Clock);
            vldCnt += int'(dram.DRAMReadDataValid);
        end
        chk("rst2_no_valid", 512'(vldCnt), 512'd0);
        chk("rst2_init_low", 512'(dram.DRAMInitComplete), 512'd0);
        chk("rst2_illegal_post", 512'(dram.IllegalCommand), 512'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
